// File: rtl/seq_contador_hex.sv
// seq_contador_hex: triangle-sweep sequencer for a 4-bit hex count.
// Sweeps 0 -> top -> 0 with a dwell at each end, repeated reps times
// (0 = until abort), stepping once per prescaler tick.
// Optional build macro SEQ_CONTADOR_IRQ_EN adds a sticky irq flag with
// an irq_clr input.
module seq_contador_hex #(
  parameter int PRESC_W = 8,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [3:0]         top,
  input  logic [3:0]         reps,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [PRESC_W-1:0] presc,
  output logic [3:0]         q,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic [3:0]         rep_cnt
`ifdef SEQ_CONTADOR_IRQ_EN
  ,
  output logic               irq,
  input  logic               irq_clr
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_HOLD_TOP,
    S_DOWN,
    S_HOLD_BOT,
    S_DONE
  } state_t;

  state_t             state;
  logic [3:0]         top_l;
  logic [3:0]         reps_l;
  logic [DWELL_W-1:0] dwell_l;
  logic [PRESC_W-1:0] presc_l;
  logic [PRESC_W-1:0] psc;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               tick;

  // Step strobe: prescaler has reached the latched reload value while running
  always_comb begin
    tick = busy && (psc == presc_l);
  end

  // Sequencer: state, count, direction, repetition and prescaler registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      q         <= '0;
      dir       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rep_cnt   <= '0;
      psc       <= '0;
      dwell_cnt <= '0;
      top_l     <= '0;
      reps_l    <= '0;
      dwell_l   <= '0;
      presc_l   <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        psc <= tick ? '0 : psc + 1'b1;
      end
      if (abort) begin
        state <= S_IDLE;
        q     <= '0;
        dir   <= 1'b0;
        busy  <= 1'b0;
        psc   <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              top_l   <= top;
              reps_l  <= reps;
              dwell_l <= dwell;
              presc_l <= presc;
              q       <= '0;
              rep_cnt <= '0;
              psc     <= '0;
              dir     <= 1'b0;
              if (top == 4'd0) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= S_UP;
                busy  <= 1'b1;
              end
            end
          end
          S_UP: begin
            if (tick) begin
              q <= q + 4'd1;
              if (q + 4'd1 == top_l) begin
                state     <= S_HOLD_TOP;
                dwell_cnt <= dwell_l;
              end
            end
          end
          S_HOLD_TOP: begin
            if (tick) begin
              if (dwell_cnt == '0) begin
                dir   <= 1'b1;
                state <= S_DOWN;
              end else begin
                dwell_cnt <= dwell_cnt - 1'b1;
              end
            end
          end
          S_DOWN: begin
            if (tick) begin
              q <= q - 4'd1;
              if (q - 4'd1 == 4'd0) begin
                state     <= S_HOLD_BOT;
                dwell_cnt <= dwell_l;
              end
            end
          end
          S_HOLD_BOT: begin
            if (tick) begin
              if (dwell_cnt == '0) begin
                rep_cnt <= rep_cnt + 4'd1;
                dir     <= 1'b0;
                if ((reps_l != 4'd0) && (rep_cnt + 4'd1 == reps_l)) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                end else begin
                  state <= S_UP;
                end
              end else begin
                dwell_cnt <= dwell_cnt - 1'b1;
              end
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SEQ_CONTADOR_IRQ_EN
  // Sticky completion flag; a new completion beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (done) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_seq_contador_hex.sv
// tb_seq_contador_hex: directed vector table plus hand-written sequences
// for seq_contador_hex.
module tb_seq_contador_hex;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] top;
  logic [3:0] reps;
  logic [3:0] dwell;
  logic [7:0] presc;
  logic [3:0] q;
  logic       dir;
  logic       busy;
  logic       done;
  logic [3:0] rep_cnt;
`ifdef SEQ_CONTADOR_IRQ_EN
  logic       irq;
  logic       irq_clr;
`endif

  int passed = 0;
  int total  = 0;

  seq_contador_hex #(.PRESC_W(8), .DWELL_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .top     (top),
    .reps    (reps),
    .dwell   (dwell),
    .presc   (presc),
    .q       (q),
    .dir     (dir),
    .busy    (busy),
    .done    (done),
    .rep_cnt (rep_cnt)
`ifdef SEQ_CONTADOR_IRQ_EN
    ,
    .irq     (irq),
    .irq_clr (irq_clr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       abort;
    logic [3:0] top;
    logic [3:0] reps;
    logic [3:0] dwell;
    logic [7:0] presc;
    logic [3:0] q;
    logic       dir;
    logic       busy;
    logic       done;
    logic [3:0] rep_cnt;
  } vec_t;

  function automatic vec_t mk(logic st, logic ab, logic [3:0] tp, logic [3:0] rp,
                              logic [3:0] dw, logic [7:0] ps, logic [3:0] eq,
                              logic ed, logic eb, logic edn, logic [3:0] er);
    vec_t v;
    v.start = st; v.abort = ab; v.top = tp; v.reps = rp; v.dwell = dw; v.presc = ps;
    v.q = eq; v.dir = ed; v.busy = eb; v.done = edn; v.rep_cnt = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t vecs [0:14];
  int   q2   [0:20];
  int   d2   [0:20];
  int   eq;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    top = '0; reps = '0; dwell = '0; presc = '0;
`ifdef SEQ_CONTADOR_IRQ_EN
    irq_clr = 1'b0;
`endif
    // Reset state
    step();
    chk("rst_q", q, 0);
    chk("rst_dir", dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rep_cnt", rep_cnt, 0);
`ifdef SEQ_CONTADOR_IRQ_EN
    chk("rst_irq", irq, 0);
`endif
    rst_n = 1'b1;
    step();

    // Table: expected outputs after each clock edge
    //             st ab top   reps dw ps   q     dir busy done rep
    vecs[0]  = mk(1, 0, 4'd3, 4'd1, 0, 0, 4'd0, 0, 1, 0, 4'd0);
    vecs[1]  = mk(0, 0, 4'd0, 4'd0, 0, 0, 4'd1, 0, 1, 0, 4'd0);
    vecs[2]  = mk(0, 0, 4'd0, 4'd0, 0, 0, 4'd2, 0, 1, 0, 4'd0);
    vecs[3]  = mk(0, 0, 4'd0, 4'd0, 0, 0, 4'd3, 0, 1, 0, 4'd0);
    vecs[4]  = mk(0, 0, 4'd0, 4'd0, 0, 0, 4'd3, 1, 1, 0, 4'd0);
    vecs[5]  = mk(0, 0, 4'd0, 4'd0, 0, 0, 4'd2, 1, 1, 0, 4'd0);
    vecs[6]  = mk(0, 0, 4'd0, 4'd0, 0, 0, 4'd1, 1, 1, 0, 4'd0);
    vecs[7]  = mk(0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 1, 1, 0, 4'd0);
    vecs[8]  = mk(0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 4'd1);
    vecs[9]  = mk(0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd1);
    // top=0: immediate done, no counting
    vecs[10] = mk(1, 0, 4'd0, 4'd1, 0, 0, 4'd0, 0, 0, 1, 4'd0);
    vecs[11] = mk(0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0);
    // abort together with start: start ignored
    vecs[12] = mk(1, 1, 4'd5, 4'd1, 0, 0, 4'd0, 0, 0, 0, 4'd0);
    // start, then abort on the first count cycle
    vecs[13] = mk(1, 0, 4'd1, 4'd3, 0, 0, 4'd0, 0, 1, 0, 4'd0);
    vecs[14] = mk(0, 1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0);

    for (int i = 0; i < 15; i++) begin
      start = vecs[i].start; abort = vecs[i].abort; top = vecs[i].top;
      reps = vecs[i].reps; dwell = vecs[i].dwell; presc = vecs[i].presc;
      step();
      chk($sformatf("vec%0d_q", i), q, vecs[i].q);
      chk($sformatf("vec%0d_dir", i), dir, vecs[i].dir);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_done", i), done, vecs[i].done);
      chk($sformatf("vec%0d_rep_cnt", i), rep_cnt, vecs[i].rep_cnt);
    end
    start = 0; abort = 0;

    // top=2 reps=2 dwell=2 presc=3: one tick every 4 cycles, q after tick k
    q2 = '{0, 1, 2, 2, 2, 2, 1, 0, 0, 0, 0, 1, 2, 2, 2, 2, 1, 0, 0, 0, 0};
    d2 = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
    start = 1; top = 4'd2; reps = 4'd2; dwell = 4'd2; presc = 8'd3;
    step();
    start = 0;
    // config changes while busy must not matter
    top = 4'hF; reps = 4'd1; dwell = 4'd0; presc = 8'd0;
    chk("s2_busy0", busy, 1);
    chk("s2_q0", q, 0);
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) start = 1;
      step();
      start = 0;
      step();
      step();
      chk($sformatf("s2_hold_q_t%0d", k), q, q2[k-1]);
      step();
      chk($sformatf("s2_q_t%0d", k), q, q2[k]);
      chk($sformatf("s2_dir_t%0d", k), dir, d2[k]);
      chk($sformatf("s2_rep_t%0d", k), rep_cnt, (k < 10) ? 0 : ((k < 20) ? 1 : 2));
      chk($sformatf("s2_done_t%0d", k), done, (k == 20) ? 1 : 0);
    end
    chk("s2_busy_end", busy, 0);
    step();
    chk("s2_done_clear", done, 0);
    chk("s2_rep_hold", rep_cnt, 2);

    // top=F reps=0 presc=0: full sweep with no wrap, abort at q=9
    start = 1; top = 4'hF; reps = 4'd0; dwell = 4'd0; presc = 8'd0;
    step();
    start = 0;
    for (int e = 1; e <= 41; e++) begin
      step();
      if (e <= 15) eq = e;
      else if (e == 16) eq = 15;
      else if (e <= 31) eq = 31 - e;
      else if (e == 32) eq = 0;
      else eq = e - 32;
      chk($sformatf("s4_q_e%0d", e), q, eq);
      chk($sformatf("s4_dir_e%0d", e), dir, (e >= 16 && e <= 31) ? 1 : 0);
      chk($sformatf("s4_busy_e%0d", e), busy, 1);
      chk($sformatf("s4_rep_e%0d", e), rep_cnt, (e >= 32) ? 1 : 0);
    end
    abort = 1;
    step();
    abort = 0;
    chk("s4_abort_q", q, 0);
    chk("s4_abort_busy", busy, 0);
    chk("s4_abort_dir", dir, 0);
    chk("s4_abort_done", done, 0);
    chk("s4_abort_rep", rep_cnt, 1);
    step();
    chk("s4_idle_busy", busy, 0);

    // Asynchronous reset mid-DOWN of the second sweep
    start = 1; top = 4'd1; reps = 4'd2; dwell = 4'd0; presc = 8'd0;
    step();
    start = 0;
    repeat (6) step();
    chk("s5_pre_q", q, 1);
    chk("s5_pre_dir", dir, 1);
    chk("s5_pre_rep", rep_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rst_q", q, 0);
    chk("s5_rst_dir", dir, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_rep", rep_cnt, 0);
    #3 rst_n = 1'b1;
    step();
    chk("s5_post_busy", busy, 0);

`ifdef SEQ_CONTADOR_IRQ_EN
    // irq follows done by one cycle; set beats simultaneous clear
    start = 1; top = 4'd1; reps = 4'd1; dwell = 4'd0; presc = 8'd0;
    step();
    start = 0;
    repeat (4) step();
    chk("irq_done", done, 1);
    chk("irq_before", irq, 0);
    irq_clr = 1;
    step();
    chk("irq_set_wins", irq, 1);
    step();
    chk("irq_cleared", irq, 0);
    irq_clr = 0;
    step();
    chk("irq_stays_clear", irq, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_contador_hex.md
Name: seq_contador_hex

Overview:
- Sequencer for a 4-bit hex up/down count.
- Runs programmed triangle sweeps: 0 up to TOP, dwell, TOP down to 0, dwell. Repeats REPS times, then signals done.
- The step rate comes from a programmable prescaler, so display and test logic get a slow, deterministic count pattern.
- Owns the count register and drives the count value and direction to downstream logic.

Parameters:
- PRESC_W, 8, width of prescaler reload value and prescaler counter.
- DWELL_W, 4, width of dwell-length field and dwell counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  one-cycle request; accepted only in IDLE or DONE.
- abort  in  1  level; forces return to IDLE.
- top  in  4  sweep peak value, latched on start.
- reps  in  4  sweep repetitions, latched on start; 0 = run until abort.
- dwell  in  DWELL_W  ticks held at the peak and at 0, latched on start.
- presc  in  PRESC_W  clock cycles per tick = presc+1, latched on start.
- q  out  4  count value.
- dir  out  1  0 = counting up, 1 = counting down.
- busy  out  1  high in UP, HOLD_TOP, DOWN, HOLD_BOT.
- done  out  1  one-cycle pulse on sequence completion.
- rep_cnt  out  4  completed sweeps in the current run.

Behaviour:
- Reset (asynchronous, active low): q=0, dir=0, busy=0, done=0, rep_cnt=0, prescaler=0, dwell counter=0, state=IDLE, latched config=0.
- Tick: the prescaler counts 0..presc_l and asserts tick in the cycle it equals presc_l, then reloads to 0. The prescaler runs only while busy. presc_l=0 gives a tick every cycle.
- All q, dwell and rep updates happen only on tick cycles, except start, abort and the top==0 case.
- States: IDLE, UP, HOLD_TOP, DOWN, HOLD_BOT, DONE.
- IDLE/DONE + start:
  - Latch config; q=0, rep_cnt=0, prescaler=0, dir=0.
  - If top==0, go to DONE next cycle with a done pulse; no counting occurs.
  - Otherwise go to UP next cycle.
- UP, on tick: q<=q+1. When q+1==top_l, go to HOLD_TOP and load the dwell counter with dwell_l.
- HOLD_TOP, on tick:
  - If the dwell counter is 0, set dir=1 and go to DOWN. dwell_l=0 therefore costs exactly one tick.
  - Otherwise decrement the dwell counter.
- DOWN, on tick: q<=q-1. When q-1==0, go to HOLD_BOT and load the dwell counter.
- HOLD_BOT, on tick when the dwell counter is 0:
  - rep_cnt<=rep_cnt+1 (4-bit wrap allowed when reps_l=0).
  - If reps_l!=0 and rep_cnt+1==reps_l: go to DONE, done=1 for that one cycle, dir=0.
  - Else: dir=0, go to UP.
- DONE: holds q=0 and rep_cnt; busy=0; waits for start.
- q never leaves 0..top_l; there is no wrap-around in either direction.
- Peak value: top_l=F is legal; q reaches F with no overflow.
- abort: highest priority in any state. Next cycle: state=IDLE, q=0, dir=0, busy=0, done=0, rep_cnt kept.
- Simultaneous abort+start: abort wins and start is ignored.
- Config changes while busy are ignored; only the latched values are used.
- start while busy is ignored.
- Reset mid-sequence: immediate return to reset values, independent of clk.

Optional Feature:
- Macro SEQ_CONTADOR_IRQ_EN.
- Defined:
  - Adds ports irq (out, 1) and irq_clr (in, 1).
  - irq is a sticky flag, set in the cycle after the done pulse.
  - irq is cleared by irq_clr; if set and clear occur in the same cycle, set wins.
  - irq resets to 0.
- Undefined: the irq and irq_clr ports and their logic are absent; all other behaviour is identical.

Test Plan:
- top=3, reps=1, dwell=0, presc=0, start -> q per tick: 1,2,3,3(hold),2,1,0,0(hold); done pulses once; rep_cnt=1; busy low afterwards.
- top=2, reps=2, dwell=2, presc=3 -> q changes only every 4 cycles; peak 2 held 3 ticks; two sweeps; done after the second; rep_cnt=2.
- top=0, start -> done pulses on the next cycle; q stays 0; busy never asserts.
- top=F, reps=0, presc=0 -> q reaches F with no wrap, returns to 0, repeats; rep_cnt increments per sweep; abort at q=9 -> IDLE next cycle, q=0, busy=0.
- Assert rst_n low mid-DOWN between clock edges -> outputs reset immediately. Start issued while busy, and top changed mid-run -> no effect on the sequence.
- SEQ_CONTADOR_IRQ_EN defined: run top=1, reps=1 -> irq rises the cycle after done; irq_clr in the same cycle as a new set keeps irq=1.
